// File: rtl/dac_spi_writer.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_writer
// Purpose  : Serialises four 16-bit setpoints (two gains, two current limits)
//            into 24-bit SPI write-and-update frames for a quad DAC. Update
//            requests are edge-detected and queued as pending bits; pending
//            channels are served lowest index first, one frame at a time.
// Ports    : clk                      - system clock, rising edge
//            rst_n                    - asynchronous active-low reset
//            enable                   - allows new frames to start
//            dds_gain / cw_gain /
//            dds_current_limit /
//            cw_current_limit         - channel 0..3 setpoints (16 bit)
//            *_update                 - channel 0..3 update request pulses
//            dac_cs_n                 - chip select, active low
//            dac_sclk                 - SPI clock, idle low
//            dac_mosi                 - serial data, MSB first
//            busy                     - high whenever a frame sequence runs
//            frame_done               - one-cycle pulse as dac_cs_n rises
//            last_channel             - channel of the most recent frame
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_writer #(
  parameter int         CLK_DIV = 4,
  parameter logic [3:0] DAC_CMD = 4'b0011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] dds_gain,
  input  logic [15:0] cw_gain,
  input  logic [15:0] dds_current_limit,
  input  logic [15:0] cw_current_limit,
  input  logic        dds_gain_update,
  input  logic        cw_gain_update,
  input  logic        dds_current_limit_update,
  input  logic        cw_current_limit_update,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  last_channel
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [8:0] C_HALF_LAST = 9'(CLK_DIV - 1);
  // GAP is one cycle short of 2*CLK_DIV: the IDLE cycle that launches the
  // next frame completes the 2*CLK_DIV chip-select-high interval.
  localparam logic [8:0] C_GAP_LAST  = 9'(2 * CLK_DIV - 2);
  // SCLK toggles counted in SHIFT; the 48th toggle is the 24th falling edge,
  // after which one more half-period elapses before HOLD.
  localparam logic [5:0] C_EDGES     = 6'd48;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [5:0]  edge_q, edge_d;
  logic [23:0] shreg_q, shreg_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;
  logic [1:0]  last_ch_q, last_ch_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  upd_q;

  logic [3:0]  w_upd;
  logic [3:0]  w_rise;
  logic [3:0]  w_clr;
  logic [1:0]  w_sel;
  logic [15:0] w_setpoint;
  logic [23:0] w_frame;
  logic        w_tick;

  assign w_upd  = {cw_current_limit_update, dds_current_limit_update,
                   cw_gain_update, dds_gain_update};
  assign w_rise = w_upd & ~upd_q;
  assign w_tick = (cnt_q == C_HALF_LAST);

  // Fixed priority: channel 0 highest.
  always_comb begin
    w_sel = 2'd3;
    if (pend_q[0])      w_sel = 2'd0;
    else if (pend_q[1]) w_sel = 2'd1;
    else if (pend_q[2]) w_sel = 2'd2;
  end

  always_comb begin
    case (w_sel)
      2'd0:    w_setpoint = dds_gain;
      2'd1:    w_setpoint = cw_gain;
      2'd2:    w_setpoint = dds_current_limit;
      default: w_setpoint = cw_current_limit;
    endcase
  end

  assign w_frame = {DAC_CMD, 2'b00, w_sel, w_setpoint};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    shreg_d   = shreg_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    last_ch_d = last_ch_q;
    w_clr     = 4'b0000;

    case (state_q)
      S_IDLE: begin
        cnt_d = 9'd0;
        if (enable && (pend_q != 4'b0000)) begin
          w_clr[w_sel] = 1'b1;
          last_ch_d    = w_sel;
          mosi_d       = w_frame[23];
          shreg_d      = {w_frame[22:0], 1'b0};
          cs_n_d       = 1'b0;
          state_d      = S_SETUP;
        end
      end

      S_SETUP: begin
        if (w_tick) begin
          cnt_d   = 9'd0;
          sclk_d  = 1'b1;
          edge_d  = 6'd1;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      S_SHIFT: begin
        if (w_tick) begin
          cnt_d = 9'd0;
          if (edge_q == C_EDGES) begin
            state_d = S_HOLD;
          end else begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + 6'd1;
            // Falling edge: present the next bit; the DAC samples on rising.
            // The 24th fall shifts out the trailing zero, leaving mosi low.
            if (sclk_q) begin
              mosi_d  = shreg_q[23];
              shreg_d = {shreg_q[22:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      S_HOLD: begin
        if (w_tick) begin
          cnt_d   = 9'd0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      S_GAP: begin
        if (cnt_q == C_GAP_LAST) begin
          cnt_d   = 9'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 9'd0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // A new request edge wins over the clear of a frame starting this cycle.
  assign pend_d = (pend_q & ~w_clr) | w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 9'd0;
      edge_q    <= 6'd0;
      shreg_q   <= 24'd0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      last_ch_q <= 2'd0;
      pend_q    <= 4'b1111;
      upd_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      shreg_q   <= shreg_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      last_ch_q <= last_ch_d;
      pend_q    <= pend_d;
      upd_q     <= w_upd;
    end
  end

  assign dac_cs_n     = cs_n_q;
  assign dac_sclk     = sclk_q;
  assign dac_mosi     = mosi_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = done_q;
  assign last_channel = last_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_spi_writer
// Purpose  : Directed self-checking bench for dac_spi_writer (CLK_DIV = 4).
//            A bus monitor decodes SPI frames; directed steps compare the
//            decoded frames, timing and status outputs to hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_spi_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] dds_gain = 16'h0000;
  logic [15:0] cw_gain = 16'h0000;
  logic [15:0] dds_current_limit = 16'h3DAE;
  logic [15:0] cw_current_limit = 16'h523D;
  logic        dds_gain_update = 1'b0;
  logic        cw_gain_update = 1'b0;
  logic        dds_current_limit_update = 1'b0;
  logic        cw_current_limit_update = 1'b0;
  logic        dac_cs_n;
  logic        dac_sclk;
  logic        dac_mosi;
  logic        busy;
  logic        frame_done;
  logic [1:0]  last_channel;

  dac_spi_writer #(.CLK_DIV(4), .DAC_CMD(4'b0011)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .enable                   (enable),
    .dds_gain                 (dds_gain),
    .cw_gain                  (cw_gain),
    .dds_current_limit        (dds_current_limit),
    .cw_current_limit         (cw_current_limit),
    .dds_gain_update          (dds_gain_update),
    .cw_gain_update           (cw_gain_update),
    .dds_current_limit_update (dds_current_limit_update),
    .cw_current_limit_update  (cw_current_limit_update),
    .dac_cs_n                 (dac_cs_n),
    .dac_sclk                 (dac_sclk),
    .dac_mosi                 (dac_mosi),
    .busy                     (busy),
    .frame_done               (frame_done),
    .last_channel             (last_channel)
  );

  always #5 clk = ~clk;

  // ---------------- cycle counter and SPI monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] fr_data[$];
  int          fr_bits[$];
  int          fr_low[$];
  int          fr_start[$];
  logic        in_frame = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [23:0] cur_data = 24'd0;
  int          cur_bits = 0;
  int          cur_low = 0;
  int          cur_start = 0;
  int          idle_viol = 0;
  int          done_cnt = 0;
  int          done_misalign = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      cur_bits = 0;
    end else begin
      if (prev_cs && !dac_cs_n) begin
        in_frame  = 1'b1;
        cur_data  = 24'd0;
        cur_bits  = 0;
        cur_low   = 0;
        cur_start = cyc;
      end
      if (!dac_cs_n && in_frame) begin
        cur_low = cur_low + 1;
        if (!prev_sclk && dac_sclk) begin
          cur_data = {cur_data[22:0], dac_mosi};
          cur_bits = cur_bits + 1;
        end
      end
      if (!prev_cs && dac_cs_n && in_frame) begin
        fr_data.push_back(cur_data);
        fr_bits.push_back(cur_bits);
        fr_low.push_back(cur_low);
        fr_start.push_back(cur_start);
        in_frame = 1'b0;
      end
      if (dac_cs_n && (dac_sclk || dac_mosi)) idle_viol = idle_viol + 1;
      if (frame_done) done_cnt = done_cnt + 1;
      if (frame_done !== (!prev_cs && dac_cs_n)) done_misalign = done_misalign + 1;
    end
    prev_cs   = dac_cs_n;
    prev_sclk = dac_sclk;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int waited = 0;
    while (fr_data.size() < target && waited < budget) begin
      @(negedge clk);
      waited = waited + 1;
    end
    check(tag, 32'(fr_data.size() >= target), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int waited = 0;
    @(negedge clk);
    while (busy && waited < 1000) begin
      @(negedge clk);
      waited = waited + 1;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic pulse(input logic [3:0] m, input int n);
    @(negedge clk);
    dds_gain_update          = m[0];
    cw_gain_update           = m[1];
    dds_current_limit_update = m[2];
    cw_current_limit_update  = m[3];
    repeat (n) @(negedge clk);
    dds_gain_update          = 1'b0;
    cw_gain_update           = 1'b0;
    dds_current_limit_update = 1'b0;
    cw_current_limit_update  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [23:0] exp);
    check({tag, "_data"}, 32'(fr_data[idx]), 32'(exp));
    check({tag, "_bits"}, 32'(fr_bits[idx]), 32'd24);
    check({tag, "_cslow"}, 32'(fr_low[idx]), 32'd200);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n0;
    int d0;
    int waited;
    logic [23:0] exp4 [4];

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(dac_cs_n), 32'd1);
    check("rst_sclk", 32'(dac_sclk), 32'd0);
    check("rst_mosi", 32'(dac_mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_lastch", 32'(last_channel), 32'd0);

    // Power-up: all four channels written in order
    n0 = fr_data.size();
    d0 = done_cnt;
    rst_n = 1'b1;
    wait_frames("pwr_timeout", n0 + 4, 4000);
    wait_idle("pwr_idle");
    check_frame("pwr_f0", n0 + 0, 24'h300000);
    check_frame("pwr_f1", n0 + 1, 24'h310000);
    check_frame("pwr_f2", n0 + 2, 24'h323DAE);
    check_frame("pwr_f3", n0 + 3, 24'h33523D);
    check("pwr_space01", 32'(fr_start[n0 + 1] - fr_start[n0]), 32'd208);
    check("pwr_space23", 32'(fr_start[n0 + 3] - fr_start[n0 + 2]), 32'd208);
    check("pwr_done_cnt", 32'(done_cnt - d0), 32'd4);
    check("pwr_lastch", 32'(last_channel), 32'd3);

    // Single update, 3-cycle pulse gives exactly one frame
    repeat (20) @(negedge clk);
    n0 = fr_data.size();
    cw_gain = 16'h1234;
    pulse(4'b0010, 3);
    wait_frames("single_timeout", n0 + 1, 1000);
    wait_idle("single_idle");
    repeat (300) @(negedge clk);
    check("single_count", 32'(fr_data.size() - n0), 32'd1);
    check_frame("single_f", n0, 24'h311234);
    check("single_lastch", 32'(last_channel), 32'd1);

    // Simultaneous requests on channels 3 and 1
    n0 = fr_data.size();
    cw_gain          = 16'h5678;
    cw_current_limit = 16'hA5A5;
    pulse(4'b1010, 2);
    wait_frames("simul_timeout", n0 + 2, 2000);
    wait_idle("simul_idle");
    check_frame("simul_f0", n0, 24'h315678);
    check_frame("simul_f1", n0 + 1, 24'h33A5A5);
    check("simul_space", 32'(fr_start[n0 + 1] - fr_start[n0]), 32'd208);
    check("simul_lastch", 32'(last_channel), 32'd3);

    // Re-request on channel 0 while its frame is on the wire
    n0 = fr_data.size();
    dds_gain = 16'h1111;
    pulse(4'b0001, 2);
    waited = 0;
    while (dac_cs_n && waited < 100) begin
      @(negedge clk);
      waited = waited + 1;
    end
    check("rereq_start", 32'(dac_cs_n), 32'd0);
    repeat (40) @(negedge clk);
    dds_gain = 16'hBEEF;
    pulse(4'b0001, 2);
    wait_frames("rereq_timeout", n0 + 2, 2000);
    wait_idle("rereq_idle");
    repeat (300) @(negedge clk);
    check("rereq_count", 32'(fr_data.size() - n0), 32'd2);
    check_frame("rereq_f0", n0, 24'h301111);
    check_frame("rereq_f1", n0 + 1, 24'h30BEEF);
    check("rereq_space", 32'(fr_start[n0 + 1] - fr_start[n0]), 32'd208);

    // Enable gating: requests held while disabled, served once enabled
    n0 = fr_data.size();
    enable            = 1'b0;
    dds_gain          = 16'h0A0A;
    cw_gain           = 16'h1B1B;
    dds_current_limit = 16'h2C2C;
    cw_current_limit  = 16'h3D3D;
    pulse(4'b1111, 2);
    repeat (300) @(negedge clk);
    check("gate_no_frames", 32'(fr_data.size() - n0), 32'd0);
    check("gate_cs_n", 32'(dac_cs_n), 32'd1);
    check("gate_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_frames("gate_timeout", n0 + 4, 4000);
    wait_idle("gate_idle");
    exp4[0] = 24'h300A0A;
    exp4[1] = 24'h311B1B;
    exp4[2] = 24'h322C2C;
    exp4[3] = 24'h333D3D;
    for (int i = 0; i < 4; i++) check("gate_frame", 32'(fr_data[n0 + i]), 32'(exp4[i]));

    // Reset mid-frame at bit 10
    repeat (10) @(negedge clk);
    pulse(4'b0100, 2);
    waited = 0;
    @(posedge clk);
    #1;
    while (cur_bits != 10 && waited < 1000) begin
      @(posedge clk);
      #1;
      waited = waited + 1;
    end
    check("midrst_bit10", 32'(cur_bits), 32'd10);
    n0 = fr_data.size();
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", 32'(dac_cs_n), 32'd1);
    check("midrst_sclk", 32'(dac_sclk), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    rst_n = 1'b1;
    wait_frames("midrst_timeout", n0 + 4, 4000);
    wait_idle("midrst_idle");
    check("midrst_done_cnt", 32'(done_cnt - d0), 32'd4);
    for (int i = 0; i < 4; i++) check_frame("midrst_frame", n0 + i, exp4[i]);

    // Whole-run bus properties
    check("idle_lines_low", 32'(idle_viol), 32'd0);
    check("done_alignment", 32'(done_misalign), 32'd0);
    check("done_vs_frames", 32'(done_cnt), 32'(fr_data.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/dac_spi_writer.md
DAC_SPI_WRITER -- requirements
Module: dac_spi_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal 2..255).
REQ-002 SHALL have parameter DAC_CMD, default 4'b0011, meaning the DAC write-and-update command nibble.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  permits new frames to start; update pulses are still captured when low.
REQ-006 SHALL have ports dds_gain, cw_gain, dds_current_limit, cw_current_limit  input  16 each  channel 0..3 setpoints.
REQ-007 SHALL have ports dds_gain_update, cw_gain_update, dds_current_limit_update, cw_current_limit_update  input  1 each  channel 0..3 update requests (multi-cycle high pulses).
REQ-008 SHALL have port dac_cs_n  output  1  DAC chip select, active-low.
REQ-009 SHALL have port dac_sclk  output  1  SPI clock, idle low.
REQ-010 SHALL have port dac_mosi  output  1  serial data, MSB first.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when dac_cs_n rises.
REQ-013 SHALL have port last_channel  output  2  index of the most recently started frame.

Function
REQ-014 SHALL register each update input and set pending[i] on a 0->1 transition only, once per pulse regardless of pulse width.
REQ-015 SHALL build the frame {DAC_CMD, 2'b00, ch[1:0], setpoint[15:0]}, 24 bits, sampling the setpoint in the cycle the frame starts.
REQ-016 SHALL in IDLE, when enable=1 and pending!=0, select the lowest pending index (fixed priority 0>1>2>3), clear that bit, latch the frame, drive cs_n=0, drive mosi=bit23, and enter SETUP in the same edge.
REQ-017 SHALL in SETUP hold CLK_DIV cycles, then raise sclk and enter SHIFT.
REQ-018 SHALL in SHIFT toggle sclk every CLK_DIV cycles and shift the next bit onto mosi on each falling edge, so the DAC samples on rising edges.
REQ-019 SHALL leave SHIFT after the 24th falling edge, with sclk=0, and enter HOLD.
REQ-020 SHALL in HOLD wait CLK_DIV cycles, then set cs_n=1, pulse frame_done, and enter GAP.
REQ-021 SHALL in GAP hold cs_n=1 for 2*CLK_DIV cycles, then return to IDLE.
REQ-022 SHALL keep cs_n low for exactly 50*CLK_DIV cycles, with 52*CLK_DIV cycles between consecutive frame starts.
REQ-023 SHALL, when a 0->1 edge occurs on the channel being transmitted, set pending again and send a second frame with the newer value.
REQ-024 SHALL give set priority over clear when the edge and the frame start fall in the same cycle.
REQ-025 SHALL let an in-flight frame complete normally when enable falls mid-frame, and start no new frame until enable=1.
REQ-026 SHALL hold mosi=0 outside frames.

Reset
REQ-027 SHALL on rst_n=0 immediately force cs_n=1, sclk=0, mosi=0, busy=0, frame_done=0, last_channel=0, state=IDLE, and edge registers=0.
REQ-028 SHALL on rst_n=0 set pending=4'b1111, so all four setpoints are written after reset once enable=1.
REQ-029 SHALL abort any frame when reset is asserted mid-frame, with no frame_done pulse.

Verification
REQ-030 Power-up: release reset with enable=1, dds_current_limit=16'h3DAE, cw_current_limit=16'h523D, gains=0 -> four frames in order ch0..ch3; frame 2 reads 24'h323DAE and frame 3 reads 24'h33523D; four frame_done pulses.
REQ-031 Single update: idle, cw_gain=16'h1234, cw_gain_update high 3 cycles -> exactly one frame 24'h311234; cs_n low 200 clk cycles at CLK_DIV=4; 24 sclk rising edges.
REQ-032 Simultaneous requests: channels 3 and 1 pulse in the same cycle -> ch1 frame then ch3 frame; start-to-start spacing 208 cycles.
REQ-033 Re-request mid-frame: dds_gain changes to 16'hBEEF and pulses during the ch0 frame -> ch0 frame with the old value completes, then a second ch0 frame carries 16'hBEEF.
REQ-034 Enable gating: enable=0, pulse all four updates -> no cs_n activity and busy=0; raise enable -> four frames ch0..ch3.
REQ-035 Reset mid-frame: assert rst_n=0 at bit 10 -> cs_n=1 and sclk=0 immediately; after release, pending=4'b1111 is re-served.
